// File: rtl/data_mem_resp.sv
// data_mem_resp: memory-stage responder for pipeline load/store requests.
// Holds a word-organised RAM of 2^ADDR_W 32-bit words and handles one
// request at a time. Stores complete in one cycle with byte enables.
// Loads stall the pipeline for READ_WAIT extra cycles and then return data
// with a one-cycle valid pulse. Misaligned or out-of-range requests are
// rejected with a one-cycle error pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (RAM contents retained)
//   mem_re     load request (sampled only when idle)
//   mem_we     store request (sampled only when idle, wins over mem_re)
//   mem_addr   byte address; must be word aligned and inside the RAM
//   mem_wdata  store data
//   mem_be     store byte enables, bit i -> mem_wdata[8i+7:8i]
//   mem_rdata  registered load data, held between loads
//   mem_rvalid one-cycle load-data-valid pulse
//   mem_stall  combinational pipeline freeze request
//   mem_err    registered one-cycle rejected-request pulse
module data_mem_resp #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned READ_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_be,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_stall,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] RW3 = 3'(READ_WAIT);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];

  logic              legal;
  logic [ADDR_W-1:0] req_idx;
  logic              wr_en;
  logic              load_go;

  assign legal   = (mem_addr[1:0] == 2'b00) && (mem_addr[31:ADDR_W+2] == '0);
  assign req_idx = mem_addr[ADDR_W+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    load_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_we) begin
          if (legal) begin
            wr_en = 1'b1;
            // Store wins a simultaneous load; the dropped load is flagged.
            err_d = mem_re;
          end else begin
            err_d = 1'b1;
          end
        end else if (mem_re) begin
          if (legal) begin
            load_go = 1'b1;
            idx_d   = req_idx;
            cnt_d   = RW3;
            if (RW3 == 3'd0) begin
              // No wait cycles: capture the word on the way into RESP.
              rdata_d  = ram[req_idx];
              rvalid_d = 1'b1;
              state_d  = RESP;
            end else begin
              state_d = WAIT;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d  = ram[idx_q];
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall covers the request cycle itself, so it cannot wait for a flop.
  assign mem_stall = !rst && ((state_q == WAIT) || load_go);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_be[i]) begin
          ram[req_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_rvalid = rvalid_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  logic [31:0] rdata  [3];
  logic        rvalid [3];
  logic        stall  [3];
  logic        err    [3];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  // Three copies share the same request stream, each with its own latency.
  data_mem_resp #(.ADDR_W(10), .READ_WAIT(2)) u_rw2 (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(rdata[0]),
    .mem_rvalid(rvalid[0]), .mem_stall(stall[0]), .mem_err(err[0]));
  data_mem_resp #(.ADDR_W(10), .READ_WAIT(0)) u_rw0 (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(rdata[1]),
    .mem_rvalid(rvalid[1]), .mem_stall(stall[1]), .mem_err(err[1]));
  data_mem_resp #(.ADDR_W(10), .READ_WAIT(7)) u_rw7 (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(rdata[2]),
    .mem_rvalid(rvalid[2]), .mem_stall(stall[2]), .mem_err(err[2]));

  function automatic int rw_of(int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 7;
    endcase
  endfunction

  function automatic bit legal(logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:12] == 20'h0);
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%h exp=%h", name, k, $time, act, exp);
    end
  endtask

  // Reference model: a transaction is timestamped by its request cycle and
  // every output is derived from the elapsed cycle count.
  int          cyc = 0;
  bit          m_busy   [3];
  int          m_t0     [3];
  int          m_idx    [3];
  logic [31:0] m_rdata  [3];
  logic        m_rvalid [3];
  logic        m_err    [3];
  logic [31:0] mram     [3][1024];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0; m_rdata[k] = '0; m_rvalid[k] = 1'b0; m_err[k] = 1'b0;
      end else begin
        m_rvalid[k] = 1'b0;
        m_err[k]    = 1'b0;
        if (m_busy[k]) begin
          if (cyc == m_t0[k] + rw_of(k)) begin
            m_rdata[k] = mram[k][m_idx[k]]; m_rvalid[k] = 1'b1;
          end else if (cyc == m_t0[k] + rw_of(k) + 1) begin
            m_busy[k] = 1'b0;
          end
        end else if (mem_we) begin
          if (legal(mem_addr)) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mram[k][mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            if (mem_re) m_err[k] = 1'b1;
          end else begin
            m_err[k] = 1'b1;
          end
        end else if (mem_re) begin
          if (legal(mem_addr)) begin
            m_busy[k] = 1'b1; m_t0[k] = cyc; m_idx[k] = int'(mem_addr[11:2]);
            if (rw_of(k) == 0) begin
              m_rdata[k] = mram[k][m_idx[k]]; m_rvalid[k] = 1'b1;
            end
          end else begin
            m_err[k] = 1'b1;
          end
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        logic exp_stall;
        exp_stall = !rst && ((m_busy[k] && cyc <= m_t0[k] + rw_of(k)) ||
                    (!m_busy[k] && mem_re && !mem_we && legal(mem_addr)));
        chk("stall",  k, 32'(stall[k]),  32'(exp_stall));
        chk("rvalid", k, 32'(rvalid[k]), 32'(m_rvalid[k]));
        chk("err",    k, 32'(err[k]),    32'(m_err[k]));
        chk("rdata",  k, rdata[k],       m_rdata[k]);
      end
    end
  end

  task automatic drive(logic re, logic we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    mem_re = re; mem_we = we; mem_addr = a; mem_wdata = d; mem_be = be;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic idle_all();
    bit done = 1'b0;
    nop();
    for (int i = 0; i < 40 && !done; i++) begin
      if (!m_busy[0] && !m_busy[1] && !m_busy[2]) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!done) chk("idle_timeout", 0, 32'd0, 32'd1);
  endtask

  int          w_first  [3];
  int          w_second [3];
  int          w_scnt   [3];
  int          w_efirst [3];
  int          w_ecnt   [3];
  logic [31:0] w_dfirst [3];
  logic [31:0] w_dlast  [3];

  // Issue one request and observe every copy for a fixed window; offsets
  // are in cycles relative to the request cycle.
  task automatic op(logic re, logic we, logic [31:0] a, logic [31:0] d,
                    logic [3:0] be, bit hold);
    idle_all();
    for (int k = 0; k < 3; k++) begin
      w_first[k] = -1; w_second[k] = -1; w_scnt[k] = 0;
      w_efirst[k] = -1; w_ecnt[k] = 0; w_dfirst[k] = 'x; w_dlast[k] = 'x;
    end
    @(posedge clk); #1;
    drive(re, we, a, d, be);
    for (int n = 0; n < 12; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        if (!hold) nop();
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (stall[k]) w_scnt[k]++;
        if (rvalid[k]) begin
          if (w_first[k] < 0) begin w_first[k] = n; w_dfirst[k] = rdata[k]; end
          else if (w_second[k] < 0) w_second[k] = n;
        end
        if (err[k]) begin
          w_ecnt[k]++;
          if (w_efirst[k] < 0) w_efirst[k] = n;
        end
        w_dlast[k] = rdata[k];
      end
    end
    @(posedge clk); #1;
    nop();
  endtask

  initial begin
    int rv_seen;
    rst = 1'b1;
    nop();
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1;
    rst = 1'b0;

    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);
      @(posedge clk); #1;
    end
    nop();

    // Full-word store then load, with the latency sweep on the other copies.
    op(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
    op(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    chk("lat_rw2",   0, 32'(w_first[0]), 32'd3);
    chk("stall_rw2", 0, 32'(w_scnt[0]),  32'd3);
    chk("data_full", 0, w_dfirst[0],     32'hDEADBEEF);
    chk("lat_rw0",   1, 32'(w_first[1]), 32'd1);
    chk("stall_rw0", 1, 32'(w_scnt[1]),  32'd1);
    chk("lat_rw7",   2, 32'(w_first[2]), 32'd8);
    chk("stall_rw7", 2, 32'(w_scnt[2]),  32'd8);
    chk("data_rw7",  2, w_dfirst[2],     32'hDEADBEEF);

    // Byte enables, then an all-zero enable mask.
    op(1'b0, 1'b1, 32'h40, 32'h11223344, 4'b0101, 1'b0);
    chk("be_noerr", 0, 32'(w_ecnt[0]), 32'd0);
    op(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 1'b0);
    chk("be0_noerr", 0, 32'(w_ecnt[0]), 32'd0);
    op(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    chk("data_be", 0, w_dfirst[0], 32'hDE22BE44);

    // Misaligned load.
    op(1'b1, 1'b0, 32'h42, 32'h0, 4'h0, 1'b0);
    chk("mis_norv",   0, 32'(w_first[0]),  32'hFFFFFFFF);
    chk("mis_nostl",  0, 32'(w_scnt[0]),   32'd0);
    chk("mis_errat",  0, 32'(w_efirst[0]), 32'd1);
    chk("mis_errcnt", 0, 32'(w_ecnt[0]),   32'd1);
    chk("mis_hold",   0, w_dlast[0],       32'hDE22BE44);

    // Out-of-range store must not alias onto word 0.
    op(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0);
    op(1'b0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b0);
    chk("oor_errat", 0, 32'(w_efirst[0]), 32'd1);
    op(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    chk("oor_ram", 0, w_dfirst[0], 32'hCAFEF00D);

    // Simultaneous load and store.
    op(1'b1, 1'b1, 32'h80, 32'h5A5A5A5A, 4'hF, 1'b0);
    chk("rw_errat", 0, 32'(w_efirst[0]), 32'd1);
    chk("rw_nostl", 0, 32'(w_scnt[0]),   32'd0);
    op(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0);
    chk("rw_data", 0, w_dfirst[0], 32'h5A5A5A5A);

    // Reset in the second wait cycle of a load.
    idle_all();
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    @(posedge clk); #1;
    nop();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_stall", 0, 32'(stall[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall1", 0, 32'(stall[0]),  32'd0);
    chk("rst_rdata",  0, rdata[0],       32'h0);
    chk("rst_rvalid", 0, 32'(rvalid[0]), 32'd0);
    rv_seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rvalid[0]) rv_seen++;
    end
    chk("rst_norv", 0, 32'(rv_seen), 32'd0);
    op(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    chk("rst_ram", 0, w_dfirst[0], 32'hDE22BE44);
    chk("rst_lat", 0, 32'(w_first[0]), 32'd3);

    // Back-to-back loads with the request held.
    op(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1);
    chk("b2b_first2",  0, 32'(w_first[0]),  32'd3);
    chk("b2b_second2", 0, 32'(w_second[0]), 32'd7);
    chk("b2b_first0",  1, 32'(w_first[1]),  32'd1);
    chk("b2b_second0", 1, 32'(w_second[1]), 32'd3);
    idle_all();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      int kind;
      @(posedge clk); #1;
      kind = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 63)) << 2;
      if (kind == 8) a = a | 32'($urandom_range(1, 3));
      else if (kind == 9) a = a | (32'h1 << $urandom_range(12, 31));
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, a, $urandom,
            4'($urandom_range(0, 15)));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    nop();
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
